// File: rtl/serial_subtractor_16bit.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start/busy/done handshake sequences operations; diff/bout hold the last result.
module serial_subtractor_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_br_next;

  // Full-subtractor cell applied to the current LSB pair and the stored borrow.
  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // A start here chains the next operation without an idle cycle.
        done = 1'b1;
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_next;
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff <= {w_d, r_res[WIDTH-1:1]};
        r_bout <= w_br_next;
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench for serial_subtractor_16bit: directed cases plus a
// randomised sweep compared against an integer-arithmetic reference.
module tb_serial_subtractor_16bit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks   = 0;
  int n_failures = 0;
  int n_ops      = 0;
  int done_cnt   = 0;

  serial_subtractor_16bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction; borrow is simply "result went negative".
  function automatic void ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                    input logic rbin, output logic [W-1:0] rd,
                                    output logic rbo);
    int r;
    r   = int'(ra) - int'(rb) - int'(rbin);
    rd  = W'(r);
    rbo = (r < 0);
  endfunction

  // Present operands with start for one edge, then scramble the inputs.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Wait (bounded) for done; counts cycles seen with busy high beforehand.
  task automatic wait_done(input string tag, output int busy_n);
    bit seen;
    seen   = 1'b0;
    busy_n = 0;
    for (int c = 0; c < W + 8; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ia,
                              input logic [W-1:0] ib, input logic ibin);
    logic [W-1:0] ed;
    logic         eb;
    ref_model(ia, ib, ibin, ed, eb);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ibin);
    int busy_n;
    start_op(ia, ib, ibin);
    n_ops++;
    wait_done(tag, busy_n);
    check({tag, "_busy_len"}, 32'(busy_n), 32'(W));
    check_result(tag, ia, ib, ibin);
  endtask

  initial begin
    int busy_n;
    int done_before;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: all-ones wrap with borrow
    run_op("t1", 16'd0, 16'd0, 1'b1);
    check("t1_const_diff", 32'(diff), 32'h0000_FFFF);
    check("t1_const_bout", 32'(bout), 32'd1);

    // 2: second op started in the DONE cycle of the first
    run_op("t2a", 16'd14, 16'd1, 1'b1);
    check("t2a_const_diff", 32'(diff), 32'd12);
    run_op("t2b", 16'd5, 16'd0, 1'b0);
    check("t2b_const_diff", 32'(diff), 32'd5);

    // 3: assorted edge values
    run_op("t3a", 16'd999, 16'd0, 1'b1);
    check("t3a_const_diff", 32'(diff), 32'd998);
    run_op("t3b", 16'h8000, 16'h0001, 1'b0);
    check("t3b_const_diff", 32'(diff), 32'h7FFF);
    run_op("t3c", 16'd1, 16'd2, 1'b0);
    check("t3c_const_bout", 32'(bout), 32'd1);

    // 4: start while busy is ignored, result unaffected
    @(posedge clk); #1;
    start_op(16'd100, 16'd40, 1'b0);
    n_ops++;
    repeat (3) begin
      @(posedge clk); #1;
    end
    a = 16'd7; b = 16'd7; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t4", busy_n);
    check("t4_busy_len", 32'(busy_n), 32'(W - 4));
    check("t4_const_diff", 32'(diff), 32'd60);
    check("t4_const_bout", 32'(bout), 32'd0);

    // 5: reset mid-run aborts with no done pulse and clears the result
    @(posedge clk); #1;
    start_op(16'd50, 16'd20, 1'b0);
    check("t5_diff_held", 32'(diff), 32'd60);
    repeat (6) begin
      @(posedge clk); #1;
    end
    done_before = done_cnt;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_diff", 32'(diff), 32'd0);
    check("t5_rst_bout", 32'(bout), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (W + 2) begin
      @(posedge clk); #1;
    end
    check("t5_no_done", 32'(done_cnt), 32'(done_before));
    run_op("t5b", 16'd50, 16'd20, 1'b0);
    check("t5b_const_diff", 32'(diff), 32'd30);

    // 6: random sweep, gaps of 0..2 idle cycles (0 = back-to-back)
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      run_op("rnd", W'($urandom), W'($urandom), 1'($urandom));
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("done_pulses", 32'(done_cnt), 32'(n_ops));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_16bit.md
Name: serial_subtractor_16bit

Overview:
- Sequential bit-serial subtractor computing diff = a - b - bin, with borrow out. It is the inverse-operation counterpart to the 16-bit carry select adder.
- Processes one bit per clock from a latched operand pair. It sits beside the adder in the ALU datapath experiments and trades area for latency.
- Uses a start/busy/done handshake so a controller or bench can sequence operations.

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on clk rising edge
- a  input  WIDTH  minuend; sampled only when start is accepted
- b  input  WIDTH  subtrahend; sampled only when start is accepted
- bin  input  1  borrow in; sampled only when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when diff/bout are updated
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out; 1 iff a < b + bin (unsigned)

Behaviour:
- One clock domain. One reset: async active-high (rst), deasserted synchronously by the environment.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0
  - diff = 0, bout = 0
  - internal shift registers, borrow FF and bit counter = 0
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0.
  - start = 1 on an edge latches a, b and bin into regA, regB and the borrow FF, clears the counter, and moves to RUN.
- RUN:
  - busy = 1.
  - Each edge processes bit 0 of regA/regB:
    - d = a0 ^ b0 ^ br
    - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - regA and regB shift right by 1. d is shifted into the MSB of the result shift register. The counter increments.
  - On the edge that processes bit WIDTH-1:
    - copy the full result shift register (including that bit) into diff
    - load br_next into bout
    - pulse done = 1
    - move to DONE
- DONE:
  - busy = 0, done = 1 for exactly this one cycle.
  - The next edge returns to IDLE.
  - start = 1 in DONE is accepted exactly as in IDLE (back-to-back operations, no dead cycle).
- Latency: start accepted at edge N, done high in the cycle following edge N+WIDTH. diff and bout are valid from that cycle on.
- diff and bout change only on the completion edge (or reset). They hold the last result through subsequent IDLE and RUN.
- start while busy = 1 is ignored. Operands are not re-sampled. a, b and bin may change freely after acceptance.
- Arithmetic: unsigned modulo 2^WIDTH; bout is the true borrow. Signed interpretation is the user's concern (overflow is not flagged).
- Reset mid-RUN: aborts immediately to IDLE. No done pulse. diff and bout clear to 0.
- done and busy are never high simultaneously.

Test Plan:
1. Reset, then start with a=0, b=0, bin=1 -> done after 16 cycles, diff=16'hFFFF, bout=1. busy high for exactly 16 cycles.
2. a=14, b=1, bin=1 -> diff=12, bout=0. Then a=5, b=0, bin=0 -> diff=5, bout=0, with start asserted in the DONE cycle of the previous operation (back-to-back, no idle cycle).
3. a=999, b=0, bin=1 -> diff=998, bout=0. Then a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0. Then a=1, b=2, bin=0 -> diff=16'hFFFF, bout=1.
4. Start a=100, b=40; pulse start again at cycle 5 with a=7, b=7 -> second start ignored, result diff=60, bout=0. Operands changed after acceptance do not affect the result.
5. Start a=50, b=20; assert rst at cycle 8 -> busy=0, diff=0, bout=0 immediately, no done pulse. After release, a fresh a=50, b=20 gives diff=30.
6. Randomised sweep of 200 vectors against a reference model computing a - b - bin -> every diff/bout matches, done pulses once per accepted start.
